// File: rtl/axi_burst_mem_responder_if.sv
// AXI3-style burst bus bundle between a DMA master and the memory responder.
// Write address/data/response and read address/data channels.
interface axi_burst_mem_responder_if #(
  parameter int addr_w = 32,
  parameter int data_w = 64,
  parameter int id_w   = 6
);
  logic [addr_w-1:0]   awaddr;
  logic [id_w-1:0]     awid;
  logic [3:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;

  logic [data_w-1:0]   wdata;
  logic [data_w/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;

  logic [id_w-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  logic [addr_w-1:0]   araddr;
  logic [id_w-1:0]     arid;
  logic [3:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;

  logic [data_w-1:0]   rdata;
  logic [id_w-1:0]     rid;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awid, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output araddr, arid, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rdata, rid, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awid, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  araddr, arid, arlen, arsize, arburst, arvalid,
    output arready,
    output rdata, rid, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_burst_mem_responder.sv
// Single-transaction AXI3 burst slave backed by a word-addressed memory.
// Alternates AW/AR grants on ties; returns DECERR/SLVERR for bad requests.
module axi_burst_mem_responder #(
  parameter int axi_addr_width_p = 32,
  parameter int axi_data_width_p = 64,
  parameter int axi_id_width_p   = 6,
  parameter logic [axi_addr_width_p-1:0] mem_base_addr_p = 32'h8000_0000,
  parameter int mem_els_p        = 4096
) (
  input  logic clk_i,
  input  logic reset_i,
  axi_burst_mem_responder_if.slave s_axi
);

  localparam int bytes_lp = axi_data_width_p / 8;
  localparam int lg_b_lp  = $clog2(bytes_lp);
  localparam int idx_w_lp = $clog2(mem_els_p);
  localparam int ew_lp    = axi_addr_width_p + 1;

  localparam logic [ew_lp-1:0] mem_lo_lp = {1'b0, mem_base_addr_p};
  localparam logic [ew_lp-1:0] mem_hi_lp =
    mem_lo_lp + ew_lp'(mem_els_p * bytes_lp);

  localparam logic [1:0] okay_lp   = 2'b00;
  localparam logic [1:0] slverr_lp = 2'b10;
  localparam logic [1:0] decerr_lp = 2'b11;

  typedef enum logic [1:0] {
    IDLE, WDATA, WRESP, RDATA
  } state_e;

  typedef logic [axi_addr_width_p-1:0] addr_t;
  typedef logic [idx_w_lp-1:0]         idx_t;

  function automatic logic [1:0] code_f(
    input addr_t      a,
    input logic [3:0] len,
    input logic [2:0] size,
    input logic [1:0] burst
  );
    logic [ew_lp-1:0] s;
    logic [ew_lp-1:0] e;
    s = {1'b0, a};
    e = s + (ew_lp'(len) << lg_b_lp);
    if (s < mem_lo_lp || s >= mem_hi_lp ||
        e < mem_lo_lp || e >= mem_hi_lp)
      return decerr_lp;
    else if (burst != 2'b01 || size != 3'(lg_b_lp))
      return slverr_lp;
    else
      return okay_lp;
  endfunction

  function automatic idx_t idx_f(input addr_t a);
    addr_t off;
    off = a - mem_base_addr_p;
    return idx_t'(off >> lg_b_lp);
  endfunction

  state_e state_q, state_d;
  logic   last_w_q;
  logic [axi_id_width_p-1:0] id_q;
  logic [3:0] len_q;
  logic [3:0] beat_q;
  idx_t       idx_q;
  logic [1:0] code_q;

  logic [axi_data_width_p-1:0] mem [mem_els_p];
  logic [axi_data_width_p-1:0] rd_word_q;

  logic grant_w, grant_r;
  logic w_hs, r_hs;
  logic is_last;
  logic rd_en;
  idx_t rd_idx;

  addr_t      req_addr;
  logic [axi_id_width_p-1:0] req_id;
  logic [3:0] req_len;
  logic [2:0] req_size;
  logic [1:0] req_burst;

  wire idle = (state_q == IDLE);

  // On a tie the side that was not served last wins.
  assign grant_w = idle && s_axi.awvalid &&
                   (!s_axi.arvalid || !last_w_q);
  assign grant_r = idle && s_axi.arvalid &&
                   (!s_axi.awvalid || last_w_q);

  assign w_hs    = (state_q == WDATA) && s_axi.wvalid;
  assign r_hs    = (state_q == RDATA) && s_axi.rready;
  assign is_last = (beat_q == len_q);

  assign req_addr  = grant_w ? s_axi.awaddr  : s_axi.araddr;
  assign req_id    = grant_w ? s_axi.awid    : s_axi.arid;
  assign req_len   = grant_w ? s_axi.awlen   : s_axi.arlen;
  assign req_size  = grant_w ? s_axi.awsize  : s_axi.arsize;
  assign req_burst = grant_w ? s_axi.awburst : s_axi.arburst;

  always_comb begin
    state_d       = state_q;
    s_axi.awready = 1'b0;
    s_axi.arready = 1'b0;
    s_axi.wready  = 1'b0;
    s_axi.bvalid  = 1'b0;
    s_axi.rvalid  = 1'b0;
    unique case (state_q)
      IDLE: begin
        s_axi.awready = grant_w;
        s_axi.arready = grant_r;
        if (grant_w)
          state_d = WDATA;
        else if (grant_r)
          state_d = RDATA;
      end
      WDATA: begin
        s_axi.wready = 1'b1;
        if (s_axi.wvalid && is_last)
          state_d = WRESP;
      end
      WRESP: begin
        s_axi.bvalid = 1'b1;
        if (s_axi.bready)
          state_d = IDLE;
      end
      RDATA: begin
        s_axi.rvalid = 1'b1;
        if (s_axi.rready && is_last)
          state_d = IDLE;
      end
    endcase
  end

  assign s_axi.bid   = (state_q == WRESP) ? id_q   : '0;
  assign s_axi.bresp = (state_q == WRESP) ? code_q : '0;
  assign s_axi.rid   = (state_q == RDATA) ? id_q   : '0;
  assign s_axi.rresp = (state_q == RDATA) ? code_q : '0;
  assign s_axi.rlast = (state_q == RDATA) && is_last;
  assign s_axi.rdata =
    ((state_q == RDATA) && (code_q == okay_lp)) ? rd_word_q : '0;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      last_w_q <= 1'b0;
      id_q     <= '0;
      len_q    <= '0;
      beat_q   <= '0;
      idx_q    <= '0;
      code_q   <= okay_lp;
    end else begin
      state_q <= state_d;
      if (grant_w || grant_r) begin
        last_w_q <= grant_w;
        id_q     <= req_id;
        len_q    <= req_len;
        beat_q   <= '0;
        idx_q    <= idx_f(req_addr);
        code_q   <= code_f(req_addr, req_len,
                           req_size, req_burst);
      end
      if (w_hs) begin
        beat_q <= beat_q + 4'd1;
        idx_q  <= idx_q + idx_t'(1);
        // A misplaced wlast taints an otherwise clean burst.
        if ((s_axi.wlast != is_last) && (code_q == okay_lp))
          code_q <= slverr_lp;
      end
      if (r_hs) begin
        beat_q <= beat_q + 4'd1;
        idx_q  <= idx_q + idx_t'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i && w_hs && (code_q == okay_lp)) begin
      for (int b = 0; b < bytes_lp; b++) begin
        if (s_axi.wstrb[b])
          mem[idx_q][8*b +: 8] <= s_axi.wdata[8*b +: 8];
      end
    end
  end

  // Beat 0 is fetched on AR accept; later beats are prefetched on each R handshake.
  assign rd_en  = grant_r || (r_hs && !is_last);
  assign rd_idx = grant_r ? idx_f(s_axi.araddr) : idx_q + idx_t'(1);

  always_ff @(posedge clk_i) begin
    if (rd_en)
      rd_word_q <= mem[rd_idx];
  end

endmodule

// File: tb/tb_axi_burst_mem_responder.sv
// Directed bench for axi_burst_mem_responder.
// Each check is an immediate assertion against hand-computed values.
module tb_axi_burst_mem_responder;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  axi_burst_mem_responder_if #(
    .addr_w(32), .data_w(64), .id_w(6)
  ) bus ();

  axi_burst_mem_responder #(
    .axi_addr_width_p(32),
    .axi_data_width_p(64),
    .axi_id_width_p(6),
    .mem_base_addr_p(32'h8000_0000),
    .mem_els_p(4096)
  ) dut (
    .clk_i(clk),
    .reset_i(reset),
    .s_axi(bus)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int n_wacc   = 0;

  logic [63:0] rbeat  [16];
  logic        rlastv [16];
  logic [1:0]  rrespv [16];
  logic [5:0]  rid_v;
  int          nbeats;
  logic [5:0]  b_id;
  logic [1:0]  b_resp;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_bus();
    bus.awaddr = '0; bus.awid = '0; bus.awlen = '0;
    bus.awsize = 3'd3; bus.awburst = 2'b01; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0;
    bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arid = '0; bus.arlen = '0;
    bus.arsize = 3'd3; bus.arburst = 2'b01; bus.arvalid = 1'b0;
    bus.rready = 1'b0;
  endtask

  task automatic set_aw(input logic [31:0] a, input logic [5:0] id,
                        input logic [3:0] len, input logic [1:0] burst);
    bus.awaddr = a; bus.awid = id; bus.awlen = len;
    bus.awsize = 3'd3; bus.awburst = burst; bus.awvalid = 1'b1;
  endtask

  task automatic set_ar(input logic [31:0] a, input logic [5:0] id,
                        input logic [3:0] len, input logic [1:0] burst);
    bus.araddr = a; bus.arid = id; bus.arlen = len;
    bus.arsize = 3'd3; bus.arburst = burst; bus.arvalid = 1'b1;
  endtask

  task automatic aw_phase(input logic [31:0] a, input logic [5:0] id,
                          input logic [3:0] len, input logic [1:0] burst);
    set_aw(a, id, len, burst);
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (bus.awready) break;
    end
    chk("aw_accept", bus.awready, 1);
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
  endtask

  task automatic ar_phase(input logic [31:0] a, input logic [5:0] id,
                          input logic [3:0] len, input logic [1:0] burst);
    set_ar(a, id, len, burst);
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (bus.arready) break;
    end
    chk("ar_accept", bus.arready, 1);
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
  endtask

  task automatic w_phase(input int n, input int last_i,
                         input logic [63:0] base,
                         input logic [7:0] strb, input int early);
    for (int i = 0; i < n; i++) begin
      bus.wdata  = base + 64'(i);
      bus.wstrb  = strb;
      bus.wlast  = (i == last_i) || (i == early);
      bus.wvalid = 1'b1;
      for (int t = 0; t < 50; t++) begin
        @(negedge clk);
        if (bus.wready) break;
      end
      chk("w_ready", bus.wready, 1);
      if (bus.wready) n_wacc++;
      @(posedge clk); #1;
    end
    bus.wvalid = 1'b0;
    bus.wlast  = 1'b0;
  endtask

  task automatic b_phase();
    bus.bready = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (bus.bvalid) break;
    end
    chk("b_valid", bus.bvalid, 1);
    b_id   = bus.bid;
    b_resp = bus.bresp;
    @(posedge clk); #1;
    bus.bready = 1'b0;
  endtask

  task automatic r_phase(input int len, input logic [3:0] pat);
    logic        stalled;
    logic        done;
    logic [63:0] sd;
    logic        sl;
    stalled = 1'b0;
    done    = 1'b0;
    sd      = '0;
    sl      = 1'b0;
    nbeats  = 0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      bus.rready = pat[cyc % 4];
      @(negedge clk);
      if (bus.rvalid) begin
        if (stalled) begin
          chk("r_stall_data", bus.rdata, sd);
          chk("r_stall_last", bus.rlast, sl);
        end
        if (bus.rready) begin
          if (nbeats < 16) begin
            rbeat[nbeats]  = bus.rdata;
            rlastv[nbeats] = bus.rlast;
            rrespv[nbeats] = bus.rresp;
          end
          rid_v   = bus.rid;
          nbeats++;
          stalled = 1'b0;
          done    = bus.rlast || (nbeats > len);
        end else begin
          stalled = 1'b1;
          sd      = bus.rdata;
          sl      = bus.rlast;
        end
      end
      @(posedge clk); #1;
    end
    bus.rready = 1'b0;
    chk("r_beats", 64'(nbeats), 64'(len + 1));
  endtask

  task automatic write1(input logic [31:0] a, input logic [63:0] d,
                        input logic [7:0] strb);
    aw_phase(a, 6'd1, 4'd0, 2'b01);
    w_phase(1, 0, d, strb, -1);
    b_phase();
  endtask

  logic        is_w;
  logic        stop_arb;
  logic [63:0] exp_b;

  initial begin
    idle_bus();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    chk("rst_awready", bus.awready, 0);
    chk("rst_arready", bus.arready, 0);
    chk("rst_wready",  bus.wready, 0);
    chk("rst_bvalid",  bus.bvalid, 0);
    chk("rst_rvalid",  bus.rvalid, 0);
    chk("rst_ids", {bus.bid, bus.rid}, 0);
    chk("rst_resp", {bus.bresp, bus.rresp, bus.rlast}, 0);
    chk("rst_rdata", bus.rdata, 0);
    @(posedge clk); #1;

    n_wacc = 0;
    aw_phase(32'h8000_0040, 6'd5, 4'd7, 2'b01);
    w_phase(8, 7, 64'h1, 8'hFF, -1);
    chk("t1_w_accepts", 64'(n_wacc), 8);
    b_phase();
    chk("t1_bid", b_id, 6'd5);
    chk("t1_bresp", b_resp, 2'b00);

    ar_phase(32'h8000_0040, 6'd9, 4'd7, 2'b01);
    r_phase(7, 4'b1111);
    chk("t1_rid", rid_v, 6'd9);
    for (int i = 0; i < 8; i++) begin
      chk("t1_rdata", rbeat[i], 64'(i + 1));
      chk("t1_rlast", rlastv[i], (i == 7));
      chk("t1_rresp", rrespv[i], 2'b00);
    end

    write1(32'h8000_0100, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    chk("t2_bresp_a", b_resp, 2'b00);
    write1(32'h8000_0100, 64'h1122_3344_5566_7788, 8'h0F);
    chk("t2_bresp_b", b_resp, 2'b00);
    ar_phase(32'h8000_0100, 6'd2, 4'd0, 2'b01);
    r_phase(0, 4'b1111);
    chk("t2_rdata", rbeat[0], 64'hFFFF_FFFF_5566_7788);
    chk("t2_rlast", rlastv[0], 1);

    ar_phase(32'h8000_0040, 6'd3, 4'd3, 2'b01);
    r_phase(3, 4'b1001);
    for (int i = 0; i < 4; i++) begin
      chk("t3_rdata", rbeat[i], 64'(i + 1));
      chk("t3_rlast", rlastv[i], (i == 3));
    end

    stop_arb = 1'b0;
    set_aw(32'h8000_0400, 6'd11, 4'd0, 2'b01);
    set_ar(32'h8000_0040, 6'd12, 4'd0, 2'b01);
    for (int g = 0; g < 5 && !stop_arb; g++) begin
      for (int t = 0; t < 50; t++) begin
        @(negedge clk);
        if (bus.awready || bus.arready) break;
      end
      chk("t4_granted", bus.awready || bus.arready, 1);
      if (!(bus.awready || bus.arready)) begin
        stop_arb = 1'b1;
      end else begin
        is_w = bus.awready;
        chk("t4_grant_order", is_w, (g % 2 == 0));
        @(posedge clk); #1;
        if (is_w) begin
          bus.awvalid = 1'b0;
          w_phase(1, 0, 64'hA0 + 64'(g), 8'hFF, -1);
          b_phase();
          chk("t4_bid", b_id, 6'd11);
          if (g < 3) bus.awvalid = 1'b1;
        end else begin
          bus.arvalid = 1'b0;
          r_phase(0, 4'b1111);
          chk("t4_rid", rid_v, 6'd12);
          chk("t4_rdata", rbeat[0], 64'h1);
          if (g < 3) bus.arvalid = 1'b1;
        end
      end
    end
    bus.awvalid = 1'b0;
    bus.arvalid = 1'b0;
    ar_phase(32'h8000_0400, 6'd13, 4'd0, 2'b01);
    r_phase(0, 4'b1111);
    chk("t4_last_write", rbeat[0], 64'hA4);

    aw_phase(32'h8000_0040, 6'd3, 4'd0, 2'b00);
    w_phase(1, 0, 64'hDEAD, 8'hFF, -1);
    b_phase();
    chk("t5_fixed_bresp", b_resp, 2'b10);
    ar_phase(32'h8000_0040, 6'd3, 4'd0, 2'b01);
    r_phase(0, 4'b1111);
    chk("t5_mem_kept", rbeat[0], 64'h1);

    ar_phase(32'h0000_0000, 6'd4, 4'd3, 2'b01);
    r_phase(3, 4'b1111);
    for (int i = 0; i < 4; i++) begin
      chk("t6_rresp", rrespv[i], 2'b11);
      chk("t6_rdata", rbeat[i], 64'h0);
    end
    chk("t6_rlast", rlastv[3], 1);

    aw_phase(32'h8000_0200, 6'd6, 4'd3, 2'b01);
    w_phase(4, 3, 64'h10, 8'hFF, 2);
    b_phase();
    chk("t7_early_bresp", b_resp, 2'b10);
    chk("t7_bid", b_id, 6'd6);

    aw_phase(32'h8000_7FF8, 6'd7, 4'd1, 2'b01);
    w_phase(2, 1, 64'h55, 8'hFF, -1);
    b_phase();
    chk("t8_end_decerr", b_resp, 2'b11);
    write1(32'h8000_7FF8, 64'hCAFE, 8'hFF);
    chk("t8_top_ok", b_resp, 2'b00);
    ar_phase(32'h8000_7FF8, 6'd7, 4'd0, 2'b01);
    r_phase(0, 4'b1111);
    chk("t8_top_rdata", rbeat[0], 64'hCAFE);

    aw_phase(32'h8000_0300, 6'd8, 4'd7, 2'b01);
    w_phase(3, 7, 64'h30, 8'hFF, -1);
    bus.wdata  = 64'h33;
    bus.wstrb  = 8'hFF;
    bus.wvalid = 1'b1;
    reset      = 1'b1;
    @(posedge clk); #1;
    reset      = 1'b0;
    bus.wvalid = 1'b0;
    @(negedge clk);
    chk("t9_wready", bus.wready, 0);
    chk("t9_valids", {bus.bvalid, bus.rvalid}, 0);
    chk("t9_readies", {bus.awready, bus.arready}, 0);
    chk("t9_outs", {bus.bid, bus.bresp, bus.rid, bus.rresp}, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t9_no_bvalid", bus.bvalid, 0);
    end
    @(posedge clk); #1;
    aw_phase(32'h8000_0300, 6'd9, 4'd1, 2'b01);
    w_phase(2, 1, 64'h77, 8'hFF, -1);
    b_phase();
    chk("t9_bresp", b_resp, 2'b00);
    ar_phase(32'h8000_0300, 6'd9, 4'd1, 2'b01);
    r_phase(1, 4'b1111);
    exp_b = 64'h77;
    chk("t9_rdata0", rbeat[0], exp_b);
    chk("t9_rdata1", rbeat[1], exp_b + 64'd1);
    chk("t9_rresp", rrespv[1], 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
